// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encoding, FSM states and op-class helpers.
package hilo_muldiv_unit_pkg;

  localparam int unsigned MULDIV_DIV_CYCLES = 32;

  typedef enum logic [3:0] {
    OpMult  = 4'd0,
    OpMultu = 4'd1,
    OpDiv   = 4'd2,
    OpDivu  = 4'd3,
    OpMadd  = 4'd4,
    OpMaddu = 4'd5,
    OpMsub  = 4'd6,
    OpMsubu = 4'd7,
    OpMthi  = 4'd8,
    OpMtlo  = 4'd9,
    OpMfhi  = 4'd10,
    OpMflo  = 4'd11,
    OpMul   = 4'd12
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StDivRun,
    StDone
  } muldiv_state_t;

  function automatic logic op_writes_hilo(input muldiv_op_t op);
    return !(op inside {OpMfhi, OpMflo, OpMul});
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op inside {OpDiv, OpDivu};
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return op inside {OpMult, OpDiv, OpMadd, OpMsub, OpMul};
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_divider_iter.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, done pulses after the last bit.
module hilo_muldiv_unit_divider_iter
  import hilo_muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;

  // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      if (w_ge) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'(MULDIV_DIV_CYCLES - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Out-of-order multiply/divide unit producing speculative HI/LO values and MUL/MFHI/MFLO results.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_issue_valid,
  output logic                 o_issue_ready,
  input  logic [3:0]           i_issue_op,
  input  logic [TAG_WIDTH-1:0] i_issue_tag,
  input  logic [31:0]          i_issue_rs,
  input  logic [31:0]          i_issue_rt,
  input  logic                 i_hilo_ready,
  output logic                 o_hilo_lock,
  input  logic [63:0]          i_hilo_rdata,
  output logic                 o_hilo_wvalid,
  output logic [63:0]          o_hilo_wdata,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [TAG_WIDTH-1:0] o_res_tag,
  output logic [31:0]          o_res_data
);

  muldiv_state_t        r_state, w_state_d;
  muldiv_op_t           w_issue_op, r_op;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [63:0]          r_snap;
  logic [63:0]          r_wdata, w_wdata_d;
  logic [31:0]          r_res_data, w_res_d;
  logic [7:0]           r_cnt;
  logic                 r_first;
  logic                 r_q_neg, r_r_neg;
  logic                 w_accept, w_load, w_signed;
  logic [63:0]          w_a_ext, w_b_ext, w_prod, w_mul_acc;
  logic [63:0]          r_pipe [MUL_STAGES];
  logic                 w_a_neg, w_b_neg;
  logic [31:0]          w_a_mag, w_b_mag;
  logic                 w_div_start, w_div_abort, w_div_busy, w_div_done;
  logic [31:0]          w_div_quo, w_div_rem, w_quo_fix, w_rem_fix;

  assign w_issue_op = muldiv_op_t'(i_issue_op);

  assign o_issue_ready = (r_state == StIdle) & ~w_div_busy & ~i_flush &
                         (i_hilo_ready | (w_issue_op == OpMul));
  assign w_accept      = i_issue_valid & o_issue_ready & ~rst;
  assign o_hilo_lock   = w_accept & op_writes_hilo(w_issue_op);

  // The multiply starts on the issue operands so the pipe holds the product after MUL_STAGES.
  assign w_signed = op_is_signed(w_issue_op);
  assign w_a_ext  = {{32{w_signed & i_issue_rs[31]}}, i_issue_rs};
  assign w_b_ext  = {{32{w_signed & i_issue_rt[31]}}, i_issue_rt};
  assign w_prod   = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    r_pipe[0] <= w_prod;
    for (int i = 1; i < int'(MUL_STAGES); i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    case (r_op)
      OpMadd, OpMaddu: w_mul_acc = r_snap + r_pipe[MUL_STAGES-1];
      OpMsub, OpMsubu: w_mul_acc = r_snap - r_pipe[MUL_STAGES-1];
      default:         w_mul_acc = r_pipe[MUL_STAGES-1];
    endcase
  end

  assign w_a_neg     = (w_issue_op == OpDiv) & i_issue_rs[31];
  assign w_b_neg     = (w_issue_op == OpDiv) & i_issue_rt[31];
  assign w_a_mag     = w_a_neg ? (~i_issue_rs + 32'd1) : i_issue_rs;
  assign w_b_mag     = w_b_neg ? (~i_issue_rt + 32'd1) : i_issue_rt;
  assign w_div_start = w_accept & op_is_div(w_issue_op);
  assign w_div_abort = i_flush | rst;
  assign w_quo_fix   = r_q_neg ? (~w_div_quo + 32'd1) : w_div_quo;
  assign w_rem_fix   = r_r_neg ? (~w_div_rem + 32'd1) : w_div_rem;

  hilo_muldiv_unit_divider_iter u_divider (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_abort     (w_div_abort),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_wdata_d = r_wdata;
    w_res_d   = r_res_data;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          unique case (w_issue_op)
            OpMthi, OpMtlo, OpMfhi, OpMflo: begin
              w_state_d = StDone;
              w_load    = 1'b1;
              w_wdata_d = i_hilo_rdata;
              w_res_d   = 32'd0;
              if (w_issue_op == OpMthi) w_wdata_d = {i_issue_rs, i_hilo_rdata[31:0]};
              if (w_issue_op == OpMtlo) w_wdata_d = {i_hilo_rdata[63:32], i_issue_rs};
              if (w_issue_op == OpMfhi) w_res_d = i_hilo_rdata[63:32];
              if (w_issue_op == OpMflo) w_res_d = i_hilo_rdata[31:0];
            end
            OpDiv, OpDivu: w_state_d = StDivRun;
            default:       w_state_d = StMulRun;
          endcase
        end
      end
      StMulRun: begin
        if (r_cnt == 8'(MUL_STAGES - 1)) begin
          w_state_d = StDone;
          w_load    = 1'b1;
          w_wdata_d = w_mul_acc;
          w_res_d   = (r_op == OpMul) ? w_mul_acc[31:0] : 32'd0;
        end
      end
      StDivRun: begin
        if (w_div_done) begin
          w_state_d = StDone;
          w_load    = 1'b1;
          w_wdata_d = {w_rem_fix, w_quo_fix};
          w_res_d   = 32'd0;
        end
      end
      StDone: begin
        if (i_res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (i_flush) begin
      w_state_d = StIdle;
      w_load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_op       <= OpMult;
      r_tag      <= '0;
      r_snap     <= '0;
      r_wdata    <= '0;
      r_res_data <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_first <= w_load;
      if (w_accept) begin
        r_op    <= w_issue_op;
        r_tag   <= i_issue_tag;
        r_snap  <= i_hilo_rdata;
        r_cnt   <= '0;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
      end else if (r_state == StMulRun) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_load) begin
        r_wdata    <= w_wdata_d;
        r_res_data <= w_res_d;
      end
    end
  end

  // The write pulse is only the first DONE cycle, and a flush in that cycle suppresses it.
  assign o_hilo_wvalid = (r_state == StDone) & r_first & op_writes_hilo(r_op) & ~i_flush & ~rst;
  assign o_hilo_wdata  = r_wdata;
  assign o_res_valid   = (r_state == StDone);
  assign o_res_tag     = r_tag;
  assign o_res_data    = r_res_data;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table plus flush, reset and back-pressure sequences.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int unsigned TagW      = 5;
  localparam int unsigned MulStages = 2;
  localparam int          LatMul    = MulStages + 1;
  localparam int          LatDiv    = 34;
  localparam int          LatMove   = 1;
  localparam int          NumVec    = 17;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] snap;
    logic        writes;
    int          lat;
    logic [63:0] wdata;
    logic [31:0] res;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [3:0]      issue_op = 4'd0;
  logic [TagW-1:0] issue_tag = '0;
  logic [31:0]     issue_rs = '0;
  logic [31:0]     issue_rt = '0;
  logic            hilo_ready = 1'b1;
  logic            hilo_lock;
  logic [63:0]     hilo_rdata = '0;
  logic            hilo_wvalid;
  logic [63:0]     hilo_wdata;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [TagW-1:0] res_tag;
  logic [31:0]     res_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   wv_count = 0;
  vec_t vecs [NumVec];

  always #5 clk = ~clk;

  always @(posedge clk) if (hilo_wvalid) wv_count <= wv_count + 1;

  hilo_muldiv_unit #(
    .TAG_WIDTH  (TagW),
    .MUL_STAGES (MulStages)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_issue_valid (issue_valid),
    .o_issue_ready (issue_ready),
    .i_issue_op    (issue_op),
    .i_issue_tag   (issue_tag),
    .i_issue_rs    (issue_rs),
    .i_issue_rt    (issue_rt),
    .i_hilo_ready  (hilo_ready),
    .o_hilo_lock   (hilo_lock),
    .i_hilo_rdata  (hilo_rdata),
    .o_hilo_wvalid (hilo_wvalid),
    .o_hilo_wdata  (hilo_wdata),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_tag     (res_tag),
    .o_res_data    (res_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, wait for completion (bounded), check the DONE cycle and the handshake.
  task automatic run_vec(input vec_t v, input logic [TagW-1:0] tag, input string name,
                         input logic hready);
    int lat;
    int wv0;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_op    = v.op;
    issue_tag   = tag;
    issue_rs    = v.rs;
    issue_rt    = v.rt;
    hilo_rdata  = v.snap;
    hilo_ready  = hready;
    res_ready   = 1'b1;
    #1;
    check({name, " issue_ready"}, 64'(issue_ready), 64'd1);
    check({name, " lock"}, 64'(hilo_lock), 64'(v.writes));
    wv0 = wv_count;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_rs    = 32'h5A5A_5A5A;
    issue_rt    = 32'hA5A5_A5A5;
    hilo_rdata  = 64'hDEAD_0000_BEEF_0000;
    hilo_ready  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 60);
    check({name, " latency"}, 64'(lat), 64'(v.lat));
    check({name, " wvalid"}, 64'(hilo_wvalid), 64'(v.writes));
    check({name, " res_tag"}, 64'(res_tag), 64'(tag));
    check({name, " res_data"}, 64'(res_data), 64'(v.res));
    check({name, " no reissue in done"}, 64'(issue_ready), 64'd0);
    if (v.writes) check({name, " wdata"}, hilo_wdata, v.wdata);
    @(posedge clk);
    @(negedge clk);
    check({name, " res_valid drop"}, 64'(res_valid), 64'd0);
    check({name, " wvalid count"}, 64'(wv_count - wv0), 64'(v.writes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int wv0;
    int rv_seen;
    vec_t v;

    vecs[0]  = '{OpMult,  32'hFFFF_FFFF, 32'd2, 64'd0, 1'b1, LatMul, 64'hFFFF_FFFF_FFFF_FFFE, 32'd0};
    vecs[1]  = '{OpMultu, 32'hFFFF_FFFF, 32'd2, 64'd0, 1'b1, LatMul, 64'h0000_0001_FFFF_FFFE, 32'd0};
    vecs[2]  = '{OpDiv,   32'hFFFF_FFF9, 32'd2, 64'd0, 1'b1, LatDiv, 64'hFFFF_FFFF_FFFF_FFFD, 32'd0};
    vecs[3]  = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b1, LatDiv,
                 64'h0000_0000_8000_0000, 32'd0};
    vecs[4]  = '{OpDivu,  32'd100, 32'd7, 64'd0, 1'b1, LatDiv, 64'h0000_0002_0000_000E, 32'd0};
    vecs[5]  = '{OpDivu,  32'd5, 32'd0, 64'd0, 1'b1, LatDiv, 64'h0000_0005_FFFF_FFFF, 32'd0};
    vecs[6]  = '{OpDiv,   32'd5, 32'd0, 64'd0, 1'b1, LatDiv, 64'h0000_0005_FFFF_FFFF, 32'd0};
    vecs[7]  = '{OpDiv,   32'hFFFF_FFFB, 32'd0, 64'd0, 1'b1, LatDiv,
                 64'hFFFF_FFFB_0000_0001, 32'd0};
    vecs[8]  = '{OpMaddu, 32'd3, 32'd5, 64'h0000_0001_0000_0000, 1'b1, LatMul,
                 64'h0000_0001_0000_000F, 32'd0};
    vecs[9]  = '{OpMsub,  32'd2, 32'd3, 64'd0, 1'b1, LatMul, 64'hFFFF_FFFF_FFFF_FFFA, 32'd0};
    vecs[10] = '{OpMadd,  32'hFFFF_FFFF, 32'd1, 64'd5, 1'b1, LatMul, 64'd4, 32'd0};
    vecs[11] = '{OpMsubu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b1, LatMul,
                 64'h0000_0001_FFFF_FFFF, 32'd0};
    vecs[12] = '{OpMtlo,  32'h0000_00AB, 32'd0, 64'h0000_0012_0000_0034, 1'b1, LatMove,
                 64'h0000_0012_0000_00AB, 32'd0};
    vecs[13] = '{OpMthi,  32'hDEAD_BEEF, 32'd0, 64'h0000_0012_0000_0034, 1'b1, LatMove,
                 64'hDEAD_BEEF_0000_0034, 32'd0};
    vecs[14] = '{OpMfhi,  32'd0, 32'd0, 64'hCAFE_F00D_1234_5678, 1'b0, LatMove, 64'd0,
                 32'hCAFE_F00D};
    vecs[15] = '{OpMflo,  32'd0, 32'd0, 64'hCAFE_F00D_1234_5678, 1'b0, LatMove, 64'd0,
                 32'h1234_5678};
    vecs[16] = '{OpMul,   32'hFFFF_FFFD, 32'd7, 64'd0, 1'b0, LatMul, 64'd0, 32'hFFFF_FFEB};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset issue_ready", 64'(issue_ready), 64'd1);
    check("reset lock", 64'(hilo_lock), 64'd0);
    check("reset wvalid", 64'(hilo_wvalid), 64'd0);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_tag", 64'(res_tag), 64'd0);
    check("reset res_data", 64'(res_data), 64'd0);
    check("reset wdata", hilo_wdata, 64'd0);

    for (int i = 0; i < NumVec; i++) begin
      run_vec(vecs[i], TagW'(i + 1), $sformatf("vec%0d", i), 1'b1);
    end

    // HI/LO not ready: MFHI blocked, MUL still accepted
    @(negedge clk);
    hilo_ready  = 1'b0;
    issue_valid = 1'b1;
    issue_op    = OpMfhi;
    #1;
    check("mfhi gated issue_ready", 64'(issue_ready), 64'd0);
    check("mfhi gated lock", 64'(hilo_lock), 64'd0);
    repeat (3) @(negedge clk);
    check("mfhi gated no result", 64'(res_valid), 64'd0);
    issue_valid = 1'b0;
    v = '{OpMul, 32'h0001_0000, 32'h0001_0001, 64'd0, 1'b0, LatMul, 64'd0, 32'h0001_0000};
    run_vec(v, 5'd20, "mul no hilo_ready", 1'b0);

    // Flush in the middle of a divide
    @(negedge clk);
    wv0 = wv_count;
    issue_valid = 1'b1;
    issue_op    = OpDiv;
    issue_tag   = 5'd9;
    issue_rs    = 32'd100;
    issue_rt    = 32'd7;
    hilo_ready  = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush blocks issue", 64'(issue_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush idle next", 64'(issue_ready), 64'd1);
    check("flush res_valid", 64'(res_valid), 64'd0);
    rv_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    check("flush no res_valid later", 64'(rv_seen), 64'd0);
    check("flush no wvalid", 64'(wv_count - wv0), 64'd0);
    run_vec(vecs[12], 5'd10, "after flush", 1'b1);

    // Flush in the first DONE cycle suppresses the write pulse
    @(negedge clk);
    wv0 = wv_count;
    issue_valid = 1'b1;
    issue_op    = OpMthi;
    issue_tag   = 5'd11;
    issue_rs    = 32'h11;
    hilo_rdata  = 64'h0000_0022_0000_0033;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    @(negedge clk);
    check("done flush res_valid", 64'(res_valid), 64'd1);
    flush = 1'b1;
    #1;
    check("done flush wvalid", 64'(hilo_wvalid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("done flush drop", 64'(res_valid), 64'd0);
    check("done flush no pulse", 64'(wv_count - wv0), 64'd0);

    // Back-pressure: res_ready low for 5 cycles after DONE
    @(negedge clk);
    wv0 = wv_count;
    res_ready   = 1'b0;
    issue_valid = 1'b1;
    issue_op    = OpMult;
    issue_tag   = 5'd7;
    issue_rs    = 32'd3;
    issue_rt    = 32'd4;
    hilo_rdata  = 64'd0;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 60);
    check("bp latency", 64'(lat), 64'(LatMul));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp res_valid held", 64'(res_valid), 64'd1);
      check("bp res_tag stable", 64'(res_tag), 64'd7);
      check("bp res_data stable", 64'(res_data), 64'd0);
      check("bp wdata stable", hilo_wdata, 64'd12);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp released", 64'(res_valid), 64'd0);
    check("bp single pulse", 64'(wv_count - wv0), 64'd1);

    // Reset in the middle of a divide
    @(negedge clk);
    issue_valid = 1'b1;
    issue_op    = OpDivu;
    issue_tag   = 5'd13;
    issue_rs    = 32'd50;
    issue_rt    = 32'd3;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wv0 = wv_count;
    #1;
    check("rst mid div res_valid", 64'(res_valid), 64'd0);
    check("rst mid div wdata", hilo_wdata, 64'd0);
    check("rst mid div res_tag", 64'(res_tag), 64'd0);
    check("rst mid div issue_ready", 64'(issue_ready), 64'd1);
    rv_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    check("rst mid div no result", 64'(rv_seen), 64'd0);
    check("rst mid div no wvalid", 64'(wv_count - wv0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
